seed_key_schedule: RTL and testbench

SEED_KEY_SCHEDULE -- requirements
Module: seed_key_schedule

---
 rtl/seed_key_schedule.sv | 162 ++++++++++++++++
 tb/tb_seed_key_schedule.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/seed_key_schedule.sv
// rtl/seed_key_schedule.sv - SEED-128 round-key generator, one round per enabled edge, with a 16-entry key store
module seed_g_function (
    input  logic [31:0] x,
    output logic [31:0] z
);
    // Entry 0 sits in the most significant byte of each table.
    localparam logic [2047:0] S1_TABLE = {
        128'hA985D6D3_541DAC25_5D43181E_51FCCA63, 128'h2844209D_E0E2C817_A58F037B_BB13D2EE,
        128'h708C3FA8_32DDF674_EC950B57_5C5BBD01, 128'h241C7398_10CCF2D9_2CE77283_9BD186C9,
        128'h6050A3EB_0DB69E4F_B75AC678_A612AFD5, 128'h61C3B441_527D8D08_1F990019_0453F7E1,
        128'hFD762F27_B08B0EAB_A26E934D_697C090A, 128'hBFEFF3C5_8714FE64_DE2E4B1A_06216B66,
        128'h02F5928A_0CB37ED0_7A4796E5_2680ADDF, 128'hA13037AE_36152238_F4A7454C_81E98497,
        128'h35CBCE3C_7111C789_75FBDAF8_945982C4, 128'hFF493967_C0CFD7B8_0F8E4223_916CDBA4,
        128'h34F148C2_6F3D2D40_BE3EBCC1_AABA4E55, 128'h3BDC687F_9CD84A56_77A0ED46_B52B65FA,
        128'hE3B9B19F_5EF9E6B2_31EA6D5F_E4F0CD88, 128'h163A58D4_62290733_E81B0579_906A2A9A
    };
    localparam logic [2047:0] S2_TABLE = {
        128'h38E82DA6_CFDEB3B8_AF6055C7_446F6B5B, 128'hC36233B5_29A0E2A7_D3911106_1CBC364B,
        128'hEF886CA8_17C416F4_C245E1D6_3F3D8E98, 128'h284EF63E_A5F90DDF_D82B667A_272FF172,
        128'h42D441C0_7367AC8B_F7AD801F_CA2CAA34, 128'hD20BEEE9_5D9418F8_57AE08C5_13CD86B9,
        128'hFF7DC131_F58A6AB1_D120D702_22046871, 128'h07DB9D99_61BEE659_DD5190DC_9AA3ABD0,
        128'h810F471A_E3EC8DBF_967B5CA2_A163234D, 128'hC89E9C3A_0C2EBA6E_9F5AF292_F34978CC,
        128'h15FB7075_7F351003_646DC674_D5B4EA09, 128'h7619FE40_12E0BD05_FA01F02A_5EA95643,
        128'h8514899B_B0E54879_97FC1E82_218C1B5F, 128'h7754B21D_254F0046_ED5852EB_7EDAC9FD,
        128'h3095653C_B6E4BB7C_0E503926_32846993, 128'h37E724A4_CB530A87_D94C838F_CE3B4AB7
    };
    localparam logic [7:0] M0 = 8'hFC;
    localparam logic [7:0] M1 = 8'hF3;
    localparam logic [7:0] M2 = 8'hCF;
    localparam logic [7:0] M3 = 8'h3F;

    function automatic logic [7:0] sbox1(input logic [7:0] v);
        return S1_TABLE[{~v, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] sbox2(input logic [7:0] v);
        return S2_TABLE[{~v, 3'b000} +: 8];
    endfunction

    logic [7:0] y0, y1, y2, y3;

    always_comb begin
        y0 = sbox1(x[7:0]);
        y1 = sbox2(x[15:8]);
        y2 = sbox1(x[23:16]);
        y3 = sbox2(x[31:24]);
        z[7:0]   = (y0 & M0) ^ (y1 & M1) ^ (y2 & M2) ^ (y3 & M3);
        z[15:8]  = (y0 & M1) ^ (y1 & M2) ^ (y2 & M3) ^ (y3 & M0);
        z[23:16] = (y0 & M2) ^ (y1 & M3) ^ (y2 & M0) ^ (y3 & M1);
        z[31:24] = (y0 & M3) ^ (y1 & M0) ^ (y2 & M1) ^ (y3 & M2);
    end
endmodule

module seed_key_schedule #(
    parameter int NUM_ROUNDS = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clk_en,
    input  logic         key_load,
    input  logic [127:0] key_in,
    input  logic [3:0]   rd_idx,
    output logic [31:0]  Key_i_0,
    output logic [31:0]  Key_i_1,
    output logic         start_f,
    output logic         busy
);
    localparam logic [31:0] KC_INIT = 32'h9E3779B9;

    typedef enum logic [1:0] {IDLE, GEN, DONE} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] k0_q, k0_d, k1_q, k1_d, k2_q, k2_d, k3_q, k3_d;
    logic [31:0] kc_q, kc_d;
    logic [63:0] store_q [NUM_ROUNDS];
    logic [63:0] store_d [NUM_ROUNDS];
    logic [31:0] key0_q, key0_d, key1_q, key1_d;
    logic        start_f_q, start_f_d, busy_q, busy_d;
    logic [31:0] g_in0, g_in1, ki0, ki1;

    assign g_in0 = k0_q + k2_q - kc_q;
    assign g_in1 = k1_q - k3_q + kc_q;

    seed_g_function u_g0 (.x(g_in0), .z(ki0));
    seed_g_function u_g1 (.x(g_in1), .z(ki1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        k0_d    = k0_q;
        k1_d    = k1_q;
        k2_d    = k2_q;
        k3_d    = k3_q;
        kc_d    = kc_q;
        store_d = store_q;
        key0_d  = key0_q;
        key1_d  = key1_q;
        if (clk_en) begin
            // Read port sees the store as it was before this edge's write.
            key0_d = store_q[rd_idx][63:32];
            key1_d = store_q[rd_idx][31:0];
            if (key_load) begin
                {k0_d, k1_d, k2_d, k3_d} = key_in;
                kc_d    = KC_INIT;
                cnt_d   = 4'd0;
                state_d = GEN;
            end else if (state_q == GEN) begin
                store_d[cnt_q] = {ki0, ki1};
                if (!cnt_q[0]) begin
                    {k0_d, k1_d} = {k1_q[7:0], k0_q, k1_q[31:8]};
                end else begin
                    {k2_d, k3_d} = {k2_q[23:0], k3_q, k2_q[31:24]};
                end
                kc_d  = {kc_q[30:0], kc_q[31]};
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'(NUM_ROUNDS - 1)) begin
                    state_d = DONE;
                end
            end
        end
        busy_d    = (state_d == GEN);
        start_f_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            k0_q      <= 32'd0;
            k1_q      <= 32'd0;
            k2_q      <= 32'd0;
            k3_q      <= 32'd0;
            kc_q      <= KC_INIT;
            for (int i = 0; i < NUM_ROUNDS; i++) begin
                store_q[i] <= 64'd0;
            end
            key0_q    <= 32'd0;
            key1_q    <= 32'd0;
            start_f_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            k0_q      <= k0_d;
            k1_q      <= k1_d;
            k2_q      <= k2_d;
            k3_q      <= k3_d;
            kc_q      <= kc_d;
            store_q   <= store_d;
            key0_q    <= key0_d;
            key1_q    <= key1_d;
            start_f_q <= start_f_d;
            busy_q    <= busy_d;
        end
    end

    assign Key_i_0 = key0_q;
    assign Key_i_1 = key1_q;
    assign start_f = start_f_q;
    assign busy    = busy_q;
endmodule

// File: tb/tb_seed_key_schedule.sv
// tb/tb_seed_key_schedule.sv - randomized bench for seed_key_schedule against a behavioural SEED key-schedule model
module tb_seed_key_schedule;
    logic         clk = 1'b0;
    logic         reset;
    logic         clk_en;
    logic         key_load;
    logic [127:0] key_in;
    logic [3:0]   rd_idx;
    logic [31:0]  Key_i_0, Key_i_1;
    logic         start_f, busy;

    int checks = 0;
    int errors = 0;

    logic [2047:0] s1_tab = {
        128'hA985D6D3_541DAC25_5D43181E_51FCCA63, 128'h2844209D_E0E2C817_A58F037B_BB13D2EE,
        128'h708C3FA8_32DDF674_EC950B57_5C5BBD01, 128'h241C7398_10CCF2D9_2CE77283_9BD186C9,
        128'h6050A3EB_0DB69E4F_B75AC678_A612AFD5, 128'h61C3B441_527D8D08_1F990019_0453F7E1,
        128'hFD762F27_B08B0EAB_A26E934D_697C090A, 128'hBFEFF3C5_8714FE64_DE2E4B1A_06216B66,
        128'h02F5928A_0CB37ED0_7A4796E5_2680ADDF, 128'hA13037AE_36152238_F4A7454C_81E98497,
        128'h35CBCE3C_7111C789_75FBDAF8_945982C4, 128'hFF493967_C0CFD7B8_0F8E4223_916CDBA4,
        128'h34F148C2_6F3D2D40_BE3EBCC1_AABA4E55, 128'h3BDC687F_9CD84A56_77A0ED46_B52B65FA,
        128'hE3B9B19F_5EF9E6B2_31EA6D5F_E4F0CD88, 128'h163A58D4_62290733_E81B0579_906A2A9A
    };
    logic [2047:0] s2_tab = {
        128'h38E82DA6_CFDEB3B8_AF6055C7_446F6B5B, 128'hC36233B5_29A0E2A7_D3911106_1CBC364B,
        128'hEF886CA8_17C416F4_C245E1D6_3F3D8E98, 128'h284EF63E_A5F90DDF_D82B667A_272FF172,
        128'h42D441C0_7367AC8B_F7AD801F_CA2CAA34, 128'hD20BEEE9_5D9418F8_57AE08C5_13CD86B9,
        128'hFF7DC131_F58A6AB1_D120D702_22046871, 128'h07DB9D99_61BEE659_DD5190DC_9AA3ABD0,
        128'h810F471A_E3EC8DBF_967B5CA2_A163234D, 128'hC89E9C3A_0C2EBA6E_9F5AF292_F34978CC,
        128'h15FB7075_7F351003_646DC674_D5B4EA09, 128'h7619FE40_12E0BD05_FA01F02A_5EA95643,
        128'h8514899B_B0E54879_97FC1E82_218C1B5F, 128'h7754B21D_254F0046_ED5852EB_7EDAC9FD,
        128'h3095653C_B6E4BB7C_0E503926_32846993, 128'h37E724A4_CB530A87_D94C838F_CE3B4AB7
    };

    logic [63:0] m_store [16];
    logic [63:0] m_rk [16];
    int          m_pos;
    bit          m_done;
    logic [63:0] m_out;

    seed_key_schedule #(.NUM_ROUNDS(16)) dut (
        .clk     (clk),
        .reset   (reset),
        .clk_en  (clk_en),
        .key_load(key_load),
        .key_in  (key_in),
        .rd_idx  (rd_idx),
        .Key_i_0 (Key_i_0),
        .Key_i_1 (Key_i_1),
        .start_f (start_f),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] sb(input logic [2047:0] tab, input logic [7:0] v);
        return tab[2047 - 8 * int'(v) -: 8];
    endfunction

    function automatic logic [31:0] g_ref(input logic [31:0] x);
        logic [7:0]  m [4];
        logic [7:0]  s [4];
        logic [31:0] z;
        m[0] = 8'hFC; m[1] = 8'hF3; m[2] = 8'hCF; m[3] = 8'h3F;
        s[0] = sb(s1_tab, x[7:0]);
        s[1] = sb(s2_tab, x[15:8]);
        s[2] = sb(s1_tab, x[23:16]);
        s[3] = sb(s2_tab, x[31:24]);
        z = '0;
        for (int j = 0; j < 4; j++)
            for (int k = 0; k < 4; k++)
                z[8*j +: 8] = z[8*j +: 8] ^ (s[k] & m[(j + k) % 4]);
        return z;
    endfunction

    task automatic build_ref(input logic [127:0] key);
        logic [31:0] k [4];
        logic [63:0] cc, t;
        logic [31:0] kc;
        k[0] = key[127:96]; k[1] = key[95:64]; k[2] = key[63:32]; k[3] = key[31:0];
        for (int i = 1; i <= 16; i++) begin
            cc = {32'h9E3779B9, 32'h9E3779B9} << (i - 1);
            kc = cc[63:32];
            m_rk[i-1] = {g_ref(k[0] + k[2] - kc), g_ref(k[1] - k[3] + kc)};
            if (i % 2 == 1) begin
                t = {k[0], k[1]};
                t = (t >> 8) | (t << 56);
                k[0] = t[63:32]; k[1] = t[31:0];
            end else begin
                t = {k[2], k[3]};
                t = (t << 8) | (t >> 56);
                k[2] = t[63:32]; k[3] = t[31:0];
            end
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_store[i] = '0;
        m_pos  = -1;
        m_done = 1'b0;
        m_out  = '0;
    endtask

    task automatic step(input bit en, input bit ld, input logic [127:0] key, input logic [3:0] rd);
        logic [63:0] nxt;
        clk_en = en; key_load = ld; key_in = key; rd_idx = rd;
        @(posedge clk);
        #1;
        if (en) begin
            nxt = m_store[rd];
            if (ld) begin
                build_ref(key);
                m_pos  = 0;
                m_done = 1'b0;
            end else if (m_pos >= 0) begin
                m_store[m_pos] = m_rk[m_pos];
                m_pos++;
                if (m_pos == 16) begin
                    m_pos  = -1;
                    m_done = 1'b1;
                end
            end
            m_out = nxt;
        end
        check_val("key_i_0", 64'(Key_i_0), 64'(m_out[63:32]));
        check_val("key_i_1", 64'(Key_i_1), 64'(m_out[31:0]));
        check_val("busy", 64'(busy), 64'(m_pos >= 0));
        check_val("start_f", 64'(start_f), 64'(m_done));
    endtask

    task automatic run_gen(input logic [127:0] key);
        step(1'b1, 1'b1, key, 4'($urandom));
        repeat (16) step(1'b1, 1'b0, 128'($urandom), 4'($urandom));
    endtask

    task automatic sweep(input bit down);
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, '0, down ? 4'(15 - i) : 4'(i));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] key_a, key_b;
        reset = 1'b0; clk_en = 1'b0; key_load = 1'b0; key_in = '0; rd_idx = '0;
        model_reset();
        #12;
        check_val("rst_key_i_0", 64'(Key_i_0), 64'd0);
        check_val("rst_key_i_1", 64'(Key_i_1), 64'd0);
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_start_f", 64'(start_f), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        // all-zero key and the published first round key
        run_gen('0);
        step(1'b1, 1'b0, '0, 4'd0);
        check_val("kat_k1_0", 64'(Key_i_0), 64'h7C8F8C7E);
        check_val("kat_k1_1", 64'(Key_i_1), 64'hC737A22C);
        sweep(1'b0);

        run_gen(128'h000102030405060708090A0B0C0D0E0F);
        sweep(1'b0);

        // enable pulsed one edge in four during generation
        step(1'b1, 1'b1, '0, 4'd3);
        for (int i = 0; i < 72; i++) step(i % 4 == 3, 1'b0, 128'($urandom), 4'($urandom));
        sweep(1'b0);

        // reload after seven rounds
        key_a = {$urandom, $urandom, $urandom, $urandom};
        key_b = {$urandom, $urandom, $urandom, $urandom};
        step(1'b1, 1'b1, key_a, 4'd0);
        repeat (7) step(1'b1, 1'b0, '0, 4'($urandom));
        run_gen(key_b);
        sweep(1'b0);

        // asynchronous reset between edges mid-generation
        run_gen({$urandom, $urandom, $urandom, $urandom});
        step(1'b1, 1'b1, key_a, 4'd0);
        repeat (5) step(1'b1, 1'b0, '0, 4'($urandom));
        #2 reset = 1'b0;
        #1;
        check_val("arst_key_i_0", 64'(Key_i_0), 64'd0);
        check_val("arst_key_i_1", 64'(Key_i_1), 64'd0);
        check_val("arst_busy", 64'(busy), 64'd0);
        check_val("arst_start_f", 64'(start_f), 64'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (20) step(1'b1, 1'b0, '0, 4'($urandom));
        run_gen(key_a);

        // decryption-order read sweep while holding DONE
        sweep(1'b1);

        for (int i = 0; i < 800; i++)
            step($urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0,
                 {$urandom, $urandom, $urandom, $urandom}, 4'($urandom));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
